// File: rtl/hilo_div_if.sv
// Handshake bundle between the HI/LO controller and the 32-cycle signed
// divider.
//   div_start    : one-cycle launch pulse (controller -> divider)
//   div_dividend : dividend, held stable for the whole run (controller -> divider)
//   div_divisor  : divisor, held stable for the whole run (controller -> divider)
//   div_busy     : divider busy (divider -> controller)
//   div_q        : quotient, valid once div_busy falls (divider -> controller)
//   div_r        : remainder, same validity as div_q (divider -> controller)
// Modports: master = controller side, slave = divider side.
interface hilo_div_if;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic [31:0] div_q;
  logic [31:0] div_r;

  modport master (
    output div_start, div_dividend, div_divisor,
    input  div_busy, div_q, div_r
  );

  modport slave (
    input  div_start, div_dividend, div_divisor,
    output div_busy, div_q, div_r
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Issue/writeback controller that sits between EX and the signed divider.
// It owns the HI/LO register pair. A DIV is launched, the pipeline is stalled
// until the divider finishes (or times out), and then the quotient is written
// to LO and the remainder to HI. In IDLE it also services MULT, MTHI and MTLO.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   div_req             : decoded DIV in EX (held while stall is high)
//   mult_we/mthi_we/mtlo_we : HI/LO write requests (honoured in IDLE only)
//   rs_val, rt_val      : dividend/divisor; rs_val is also the MTHI/MTLO source
//   mult_prod           : 64-bit product; [63:32] goes to HI, [31:0] to LO
//   div                 : divider handshake (master side)
//   stall               : freezes PC, IF/ID and ID/EX
//   hi, lo              : HI/LO registers
//   div_err             : sticky divider-timeout flag
module hilo_div_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_req,
  input  logic        mult_we,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [63:0] mult_prod,
  hilo_div_if.master  div,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      dividend;
  logic [31:0]      divisor;
  logic             launch;
  logic             capture;
  logic             timeout;
  logic             start;

  assign cnt_inc          = cnt + CNT_W'(1);
  assign div.div_start    = start;
  assign div.div_dividend = dividend;
  assign div.div_divisor  = divisor;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        // A divide by zero is never launched: the instruction simply
        // retires with HI/LO untouched.
        if (div_req && (rt_val != '0)) begin
          launch     = 1'b1;
          stall      = 1'b1;
          state_next = START;
        end
      end
      START: begin
        start      = 1'b1;
        stall      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (!div.div_busy) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (cnt_inc == TMO_LIM) begin
          // This is the TIMEOUT-th WAIT cycle with the divider still busy.
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // stall is low here so the held DIV retires; div_req is deliberately
        // not looked at, otherwise the same instruction would relaunch.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      dividend <= '0;
      divisor  <= '0;
      cnt      <= '0;
      div_err  <= 1'b0;
    end else begin
      if (launch) begin
        dividend <= rs_val;
        divisor  <= rt_val;
        div_err  <= 1'b0;
      end

      if (state == START) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt_inc;
      end

      if (capture) begin
        lo <= div.div_q;
        hi <= div.div_r;
      end

      if (timeout) begin
        div_err <= 1'b1;
      end

      // Single-cycle HI/LO writes; only the highest-priority one applies.
      if ((state == IDLE) && !div_req) begin
        if (mult_we) begin
          hi <= mult_prod[63:32];
          lo <= mult_prod[31:0];
        end else if (mthi_we) begin
          hi <= rs_val;
        end else if (mtlo_we) begin
          lo <= rs_val;
        end
      end
    end
  end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Issue/writeback controller between the EX stage and the 32-cycle signed divider (DIV block).
- Launches a divide on a decoded DIV, stalls the pipeline until the divider finishes, then writes quotient to LO and remainder to HI.
- Owns the HI/LO register pair: also services MULT (64-bit product write), MTHI and MTLO, and drives HI/LO to the MFHI/MFLO read path.

Parameters:
- TIMEOUT, 40, max cycles in WAIT with div_busy high before the divide is aborted.
- CNT_W, 6, width of the WAIT cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; shared with the divider.
- div_req  in  1  decoded DIV in EX; held high by the pipeline while stall is high.
- mult_we  in  1  MULT in EX; write mult_prod.
- mthi_we  in  1  MTHI in EX.
- mtlo_we  in  1  MTLO in EX.
- rs_val  in  32  dividend for DIV; source value for MTHI/MTLO.
- rt_val  in  32  divisor for DIV.
- mult_prod  in  64  product from the combinational multiplier: [63:32] goes to HI, [31:0] goes to LO.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  32  latched dividend; held stable from START until DONE.
- div_divisor  out  32  latched divisor; held stable from START until DONE.
- div_busy  in  1  divider busy.
- div_q  in  32  divider quotient; valid when div_busy is low after a run.
- div_r  in  32  divider remainder; same validity as div_q.
- stall  out  1  freezes PC, IF/ID and ID/EX.
- hi  out  32  HI register.
- lo  out  32  LO register.
- div_err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous): state=IDLE, hi=0, lo=0, div_start=0, operand latches=0, counter=0, div_err=0, stall=0. A reset mid-divide aborts the operation; no HI/LO write occurs.
- State register with four states: IDLE, START, WAIT, DONE.
- IDLE:
  - div_req=1 with rt_val!=0: latch rs_val/rt_val, clear div_err, go to START.
  - div_req=1 with rt_val==0: no launch, HI/LO unchanged, stall=0, stay in IDLE.
  - Otherwise, single-cycle writes at the clock edge, with priority mult_we > mthi_we > mtlo_we. Only the highest-priority request is applied.
- START: div_start=1 for exactly this cycle; counter cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - div_busy==0: lo<=div_q, hi<=div_r at the edge; next state DONE.
  - Counter reaches TIMEOUT with div_busy still 1: set div_err, HI/LO unchanged, next state DONE.
- DONE: stall=0 so the DIV retires at this edge; div_req is ignored; next state IDLE unconditionally. This prevents a relaunch of the same held instruction.
- stall = (state==IDLE & div_req & rt_val!=0) | state==START | state==WAIT. It is combinational.
- Latency for div_req first seen at cycle 0:
  - START in cycle 1; divider busy from cycle 2 through cycle 33.
  - WAIT captures the result at the end of cycle 34.
  - DONE in cycle 35 with new HI/LO visible.
  - stall is high in cycles 0–34 (35 cycles).
- mult_we, mthi_we and mtlo_we are ignored in every state except IDLE.
- hi and lo are direct register outputs. An MFHI/MFLO in the same cycle as a write reads the old value; forwarding is handled elsewhere.
- Sign handling and result signs are the divider's responsibility. This block passes div_q and div_r through unmodified.

Test Plan:
- Reset, then div_req with rs=100, rt=7 -> div_start pulses only in cycle 1; stall high for 35 cycles; in DONE, lo=14 and hi=2; no second div_start.
- div_req with rs=-100 (0xFFFFFF9C), rt=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); div_dividend and div_divisor stable throughout.
- div_req with rt=0, hi=0x1234, lo=0x5678 -> stall never asserts, div_start never pulses, HI/LO unchanged.
- In IDLE, mult_we with prod=0x00000001_FFFFFFFE -> next cycle hi=1, lo=0xFFFFFFFE. mthi_we and mtlo_we together with rs=0xAA -> only HI is written. mtlo_we asserted during WAIT -> LO is unchanged.
- Stub divider holding div_busy=1 forever -> after 40 WAIT cycles div_err=1, stall drops, HI/LO unchanged. The next valid div_req clears div_err.
- Assert reset in cycle 10 of a divide -> state IDLE, stall=0, hi=lo=0 immediately. A fresh div_req after reset completes correctly.
